// File: rtl/receipt_chain_sequencer_if.sv
// Receipt stream, integrity-checker handshake and status bundle for receipt_chain_sequencer.
// master = the upstream core/checker/status side; slave = the sequencer.
interface receipt_chain_sequencer_if #(
  parameter int IDX_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pre_mu;
  logic [31:0]      in_post_mu;
  logic [7:0]       in_opcode;
  logic [31:0]      in_operand;
  logic             in_chain_first;

  logic             chk_valid;
  logic [31:0]      chk_pre_mu;
  logic [31:0]      chk_post_mu;
  logic [7:0]       chk_opcode;
  logic [31:0]      chk_operand;
  logic             chk_chain_mode;
  logic [31:0]      chk_prev_post_mu;
  logic             chk_integrity_ok;
  logic             chk_chain_ok;
  logic [31:0]      chk_error_code;

  logic             clear_status;
  logic [IDX_W-1:0] receipts_checked;
  logic [IDX_W-1:0] receipts_failed;
  logic             fail_seen;
  logic [IDX_W-1:0] first_fail_idx;
  logic [31:0]      first_fail_code;
  logic             busy;

  modport master (
    output in_valid, in_pre_mu, in_post_mu, in_opcode, in_operand, in_chain_first,
    input  in_ready,
    input  chk_valid, chk_pre_mu, chk_post_mu, chk_opcode, chk_operand,
           chk_chain_mode, chk_prev_post_mu,
    output chk_integrity_ok, chk_chain_ok, chk_error_code,
    output clear_status,
    input  receipts_checked, receipts_failed, fail_seen, first_fail_idx,
           first_fail_code, busy
  );

  modport slave (
    input  in_valid, in_pre_mu, in_post_mu, in_opcode, in_operand, in_chain_first,
    output in_ready,
    output chk_valid, chk_pre_mu, chk_post_mu, chk_opcode, chk_operand,
           chk_chain_mode, chk_prev_post_mu,
    input  chk_integrity_ok, chk_chain_ok, chk_error_code,
    input  clear_status,
    output receipts_checked, receipts_failed, fail_seen, first_fail_idx,
           first_fail_code, busy
  );
endinterface

// File: rtl/receipt_chain_sequencer.sv
// Buffers mu-receipts in a FIFO, issues them one per two cycles to the integrity checker,
// tracks chain context and accumulates pass/fail statistics from the checker verdicts.
module receipt_chain_sequencer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  receipt_chain_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pre;
    logic [31:0] post;
    logic [7:0]  opcode;
    logic [31:0] operand;
    logic        chain_first;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT} state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  entry_t           head;
  state_t           state;
  logic             chain_active;
  logic [31:0]      last_post;

  logic [IDX_W-1:0] checked, failed, fail_idx;
  logic             seen;
  logic [31:0]      fail_code;
  logic [IDX_W-1:0] checked_n, failed_n, fail_idx_n;
  logic             seen_n;
  logic [31:0]      fail_code_n;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  // the head leaves the FIFO on the edge that enters ISSUE
  assign pop   = (state != S_ISSUE) && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{pre: bus.in_pre_mu, post: bus.in_post_mu, opcode: bus.in_opcode,
                       operand: bus.in_operand, chain_first: bus.in_chain_first};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      bus.chk_valid        <= 1'b0;
      bus.chk_pre_mu       <= '0;
      bus.chk_post_mu      <= '0;
      bus.chk_opcode       <= '0;
      bus.chk_operand      <= '0;
      bus.chk_chain_mode   <= 1'b0;
      bus.chk_prev_post_mu <= '0;
      chain_active         <= 1'b0;
      last_post            <= '0;
    end else begin
      case (state)
        S_ISSUE: begin
          state         <= S_COLLECT;
          bus.chk_valid <= 1'b0;
        end
        default: begin
          if (!empty) begin
            state                <= S_ISSUE;
            bus.chk_valid        <= 1'b1;
            bus.chk_pre_mu       <= head.pre;
            bus.chk_post_mu      <= head.post;
            bus.chk_opcode       <= head.opcode;
            bus.chk_operand      <= head.operand;
            bus.chk_chain_mode   <= chain_active && !head.chain_first;
            bus.chk_prev_post_mu <= last_post;
            // chain context advances on issue, independent of the verdict
            last_post            <= head.post;
            chain_active         <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // clear first, then layer any verdict collected this cycle on top of it
  always_comb begin
    checked_n   = bus.clear_status ? '0 : checked;
    failed_n    = bus.clear_status ? '0 : failed;
    seen_n      = bus.clear_status ? 1'b0 : seen;
    fail_idx_n  = bus.clear_status ? '0 : fail_idx;
    fail_code_n = bus.clear_status ? '0 : fail_code;
    if (state == S_COLLECT) begin
      if (!(bus.chk_integrity_ok && bus.chk_chain_ok)) begin
        if (failed_n != '1) failed_n = failed_n + 1'b1;
        if (!seen_n) begin
          seen_n      = 1'b1;
          fail_idx_n  = checked_n;
          fail_code_n = bus.chk_error_code;
        end
      end
      if (checked_n != '1) checked_n = checked_n + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checked   <= '0;
      failed    <= '0;
      seen      <= 1'b0;
      fail_idx  <= '0;
      fail_code <= '0;
    end else begin
      checked   <= checked_n;
      failed    <= failed_n;
      seen      <= seen_n;
      fail_idx  <= fail_idx_n;
      fail_code <= fail_code_n;
    end
  end

  assign bus.in_ready         = !full;
  assign bus.busy             = !empty || (state != S_IDLE);
  assign bus.receipts_checked = checked;
  assign bus.receipts_failed  = failed;
  assign bus.fail_seen        = seen;
  assign bus.first_fail_idx   = fail_idx;
  assign bus.first_fail_code  = fail_code;
endmodule
